// File: rtl/manchester_decoder.sv
// -----------------------------------------------------------------------------
// manchester_decoder
//   Decodes a Manchester or inverse-Manchester serial line that is sampled
//   once per half-bit. Bits are assembled LSB first into bytes. A byte is
//   delivered with a one-cycle data_valid pulse, together with a flag that
//   tells whether any of its bits had a code error. The align input marks
//   the first half of bit 0.
//
// Optional feature macro: MANCH_DEC_AUTOSLIP_EN
//   When this macro is defined, the decoder shifts its phase by one half-bit
//   after two consecutive code errors while it is unlocked. This lets it find
//   the correct half-bit alignment without an align pulse.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   decode_mode  in   0 = Manchester, 1 = inverse Manchester
//   line_in      in   serial line, one half-bit per clk
//   align        in   pulse: current line_in is first half of bit 0
//   data_out     out  [7:0] last decoded byte (held between pulses)
//   data_valid   out  one-cycle pulse qualifying data_out / byte_err
//   code_err     out  one-cycle pulse: bit whose halves were equal
//   byte_err     out  delivered byte contained a code error
//   locked       out  one clean byte seen since last align / error
// -----------------------------------------------------------------------------
module manchester_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       decode_mode,
  input  logic       line_in,
  input  logic       align,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       code_err,
  output logic       byte_err,
  output logic       locked
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t            r_phase,   w_phase_nx;
  logic              r_first,   w_first_nx;
  logic [IDX_W-1:0]  r_idx,     w_idx_nx;
  logic [BYTE_W-1:0] r_shift,   w_shift_nx;
  logic              r_sticky,  w_sticky_nx;
  logic [BYTE_W-1:0] r_data,    w_data_nx;
  logic              r_valid,   w_valid_nx;
  logic              r_cerr,    w_cerr_nx;
  logic              r_berr,    w_berr_nx;
  logic              r_locked,  w_locked_nx;
`ifdef MANCH_DEC_AUTOSLIP_EN
  logic              r_err_prev, w_err_prev_nx;
`endif

  logic w_bit;
  logic w_bad;

  // Decoded bit value and the code-violation test for the current pair
  assign w_bit = r_first ^ decode_mode;
  assign w_bad = (line_in == r_first);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= PH_FIRST;
      r_first    <= 1'b0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_sticky   <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_cerr     <= 1'b0;
      r_berr     <= 1'b0;
      r_locked   <= 1'b0;
`ifdef MANCH_DEC_AUTOSLIP_EN
      r_err_prev <= 1'b0;
`endif
    end else begin
      r_phase    <= w_phase_nx;
      r_first    <= w_first_nx;
      r_idx      <= w_idx_nx;
      r_shift    <= w_shift_nx;
      r_sticky   <= w_sticky_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
      r_cerr     <= w_cerr_nx;
      r_berr     <= w_berr_nx;
      r_locked   <= w_locked_nx;
`ifdef MANCH_DEC_AUTOSLIP_EN
      r_err_prev <= w_err_prev_nx;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    w_phase_nx    = r_phase;
    w_first_nx    = r_first;
    w_idx_nx      = r_idx;
    w_shift_nx    = r_shift;
    w_sticky_nx   = r_sticky;
    w_data_nx     = r_data;
    w_valid_nx    = 1'b0;
    w_cerr_nx     = 1'b0;
    w_berr_nx     = r_berr;
    w_locked_nx   = r_locked;
`ifdef MANCH_DEC_AUTOSLIP_EN
    w_err_prev_nx = r_err_prev;
`endif

    if (align) begin
      // Restart at bit 0. This overrides a pending second half.
      w_first_nx    = line_in;
      w_phase_nx    = PH_SECOND;
      w_idx_nx      = '0;
      w_shift_nx    = '0;
      w_sticky_nx   = 1'b0;
      w_locked_nx   = 1'b0;
`ifdef MANCH_DEC_AUTOSLIP_EN
      w_err_prev_nx = 1'b0;
`endif
    end else begin
      case (r_phase)
        PH_FIRST: begin
          w_first_nx = line_in;
          w_phase_nx = PH_SECOND;
        end
        PH_SECOND: begin
          w_cerr_nx = w_bad;
          if (w_bad) begin
            w_locked_nx = 1'b0;
          end
`ifdef MANCH_DEC_AUTOSLIP_EN
          if (w_bad && r_err_prev && !r_locked) begin
            // Slip: reuse this sample as a first half, keep bit_index
            w_first_nx    = line_in;
            w_phase_nx    = PH_SECOND;
            w_sticky_nx   = 1'b1;
            w_err_prev_nx = 1'b0;
          end else begin
            w_err_prev_nx = w_bad;
`endif
            w_shift_nx[r_idx] = w_bit;
            w_phase_nx        = PH_FIRST;
            w_idx_nx          = r_idx + IDX_W'(1);
            w_sticky_nx       = r_sticky | w_bad;
            if (r_idx == IDX_W'(BYTE_W - 1)) begin
              // Byte complete: publish it and restart error accounting
              w_data_nx   = w_shift_nx;
              w_valid_nx  = 1'b1;
              w_berr_nx   = r_sticky | w_bad;
              w_sticky_nx = 1'b0;
              if (!(r_sticky | w_bad)) begin
                w_locked_nx = 1'b1;
              end
            end
`ifdef MANCH_DEC_AUTOSLIP_EN
          end
`endif
        end
        default: begin
          w_phase_nx = PH_FIRST;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign code_err   = r_cerr;
  assign byte_err   = r_berr;
  assign locked     = r_locked;

endmodule
